// File: rtl/dmem_responder_pkg.sv
// Shared types and defaults for the data-memory responder.
// Optional feature macro: DMEM_CLEAR_ON_RESET_EN (zero-sweep of the array on reset).
package dmem_responder_pkg;

    typedef logic [31:0] u32;
    typedef logic [31:0] word_t;

    localparam int unsigned DMEM_ADDR_WIDTH = 10;
    localparam int unsigned DMEM_SB_DEPTH   = 4;
    localparam int unsigned DMEM_WR_LAT     = 2;

    // Word index is kept zero-extended to 32 bits so the entry layout is fixed.
    typedef struct packed {
        u32    widx;
        word_t wdata;
    } sb_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        CLEAR
    } dmem_state_e;

    // Byte address to word index; drops the byte offset and aliases modulo 2^aw words.
    function automatic u32 word_index(input u32 addr, input int unsigned aw);
        return (addr >> 2) & ((u32'(1) << aw) - u32'(1));
    endfunction

endpackage

// File: rtl/dmem_responder_store_buffer.sv
// Circular store buffer with youngest-match lookup for load forwarding.
module store_buffer
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = DMEM_SB_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  sb_entry_t                    push_entry,
    input  logic                         pop,
    output sb_entry_t                    head_entry,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    output logic                         empty,
    input  u32                           lk_widx,
    output logic                         hit,
    output word_t                        hit_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    sb_entry_t          entries [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   cnt;

    // Pointer and occupancy tracking; push and pop may happen on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            if (push && !pop)      cnt <= cnt + CNT_W'(1);
            else if (pop && !push) cnt <= cnt - CNT_W'(1);
        end
    end

    // Entry storage; contents need no reset because occupancy gates every use.
    always_ff @(posedge clk) begin
        if (push && !reset) entries[tail] <= push_entry;
    end

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            idx = head + PTR_W'(i);
            if (CNT_W'(i) < cnt && entries[idx].widx == lk_widx) begin
                hit      = 1'b1;
                hit_data = entries[idx].wdata;
            end
        end
    end

    assign head_entry = entries[head];
    assign count      = cnt;
    assign full       = (cnt == CNT_W'(DEPTH));
    assign empty      = (cnt == '0);

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: posted stores through a store buffer, drained to the
// word array at WR_LAT cycles per write; loads forward from pending stores.
// Optional feature macro: DMEM_CLEAR_ON_RESET_EN (reset zero-sweeps the array).
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DMEM_ADDR_WIDTH,
    parameter int unsigned SB_DEPTH   = DMEM_SB_DEPTH,
    parameter int unsigned WR_LAT     = DMEM_WR_LAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_addr,
    input  logic [31:0] write_data,
    input  logic        write_enable,
    output logic [31:0] read_data,
    output logic        mem_ready,
    output logic        sb_empty
);

    localparam int unsigned CNT_W = $clog2(SB_DEPTH) + 1;
    localparam int unsigned LAT_W = $clog2(WR_LAT + 1);
    localparam int unsigned WORDS = 2 ** ADDR_WIDTH;

    word_t              mem_array [WORDS];
    dmem_state_e        state;
    logic [LAT_W-1:0]   lat_cnt;

    u32                 widx;
    sb_entry_t          head_entry;
    logic [CNT_W-1:0]   sb_count;
    logic               sb_full;
    logic               sb_hit;
    word_t              sb_hit_data;
    logic               push;
    logic               do_commit;
    logic               unused_bits;

`ifdef DMEM_CLEAR_ON_RESET_EN
    logic [ADDR_WIDTH-1:0] clr_idx;
    logic                  clr_we;
`endif

    assign widx      = word_index(data_addr, ADDR_WIDTH);
    assign push      = write_enable && mem_ready && !reset;
    assign do_commit = !reset && (state == BUSY) && (lat_cnt == '0);

`ifdef DMEM_CLEAR_ON_RESET_EN
    assign clr_we    = !reset && (state == CLEAR);
    assign mem_ready = !sb_full && (state != CLEAR);
`else
    assign mem_ready = !sb_full;
`endif

    store_buffer #(.DEPTH(SB_DEPTH)) u_sb (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry ('{widx: widx, wdata: write_data}),
        .pop        (do_commit),
        .head_entry (head_entry),
        .count      (sb_count),
        .full       (sb_full),
        .empty      (sb_empty),
        .lk_widx    (widx),
        .hit        (sb_hit),
        .hit_data   (sb_hit_data)
    );

    // Drain FSM: wait WR_LAT cycles per write, chain directly while entries remain.
    always_ff @(posedge clk) begin
        if (reset) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
            state   <= CLEAR;
            clr_idx <= '0;
`else
            state   <= IDLE;
`endif
            lat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!sb_empty) begin
                        state   <= BUSY;
                        lat_cnt <= LAT_W'(WR_LAT - 1);
                    end
                end
                BUSY: begin
                    if (lat_cnt != '0) begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end else if (sb_count > CNT_W'(1) || push) begin
                        lat_cnt <= LAT_W'(WR_LAT - 1);
                    end else begin
                        state <= IDLE;
                    end
                end
                CLEAR: begin
`ifdef DMEM_CLEAR_ON_RESET_EN
                    clr_idx <= clr_idx + ADDR_WIDTH'(1);
                    if (clr_idx == '1) state <= IDLE;
`else
                    state <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array write port: buffer commits, or the reset sweep when enabled.
    always_ff @(posedge clk) begin
        if (do_commit) begin
            mem_array[head_entry.widx[ADDR_WIDTH-1:0]] <= head_entry.wdata;
        end
`ifdef DMEM_CLEAR_ON_RESET_EN
        else if (clr_we) begin
            mem_array[clr_idx] <= '0;
        end
`endif
    end

    // Loads: youngest pending store wins, else the array.
    assign read_data = sb_hit ? sb_hit_data : mem_array[widx[ADDR_WIDTH-1:0]];

    assign unused_bits = ^{widx[31:ADDR_WIDTH], head_entry.widx[31:ADDR_WIDTH]};

endmodule
